mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue/capture controller between the EX-stage operand path and the iterative multiplier. It decodes RV32M multiply requests (funct3 000–011) and latches the operands. It holds a stable multiplier select for the full operation, stalls the pipeline until the result is captured, and then parks the multiplier select at 000 so the multiplier resets cleanly before the next operation. It also produces a one-cycle writeback strobe carrying the destination register and the 32-bit result.

## Interface
- No parameters.
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  EX holds an M-extension instruction
- req_funct3  in  3  RV32M funct3; 000 mul, 001 mulh, 010 mulhsu, 011 mulhu; 1xx is ignored
- req_rs1  in  32  operand a
- req_rs2  in  32  operand b
- req_rd  in  5  destination register
- flush  in  1  pipeline flush; kills any in-flight operation
- stall  out  1  combinational; holds IF/ID/EX while high
- mul_sel  out  3  registered select to multiplier; 001/010/011/100 = mul/mulh/mulhsu/mulhu, 000 = idle
- mul_a, mul_b  out  32  registered operands to multiplier
- mul_ready  in  1  multiplier result-valid level
- mul_res  in  32  multiplier result, already high/low selected
- wb_valid  out  1  one-cycle result strobe
- wb_rd  out  5  destination register for wb_data
- wb_data  out  32  product bits

## Operation
- req_mul = req_valid && !req_funct3[2].
- stall = req_mul && !(state==WAIT && mul_ready && !flush).
- Zero-bypass applies only when MUL_ZERO_BYPASS_EN is defined (see Configuration). When it applies, stall is also forced 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - mul_sel = 000.
  - req_mul && !flush: latch rs1/rs2/rd, set mul_sel = funct3 + 1, go to ISSUE.
  - req with funct3[2]=1 is not accepted and does not stall.
- ISSUE: one cycle; mul_sel held; go to WAIT. If flush is high, go to DRAIN instead.
- WAIT:
  - mul_sel held.
  - On mul_ready: capture mul_res into wb_data, go to DRAIN, wb_valid=1 in the next cycle.
  - flush (including the same cycle as mul_ready): go to DRAIN with no wb_valid. Flush wins.
- DRAIN:
  - mul_sel = 000.
  - Stay while mul_ready=1.
  - Go to IDLE on the first cycle with mul_ready=0; minimum one cycle in DRAIN.
- Requests presented outside IDLE are ignored, apart from stall.
- mul_sel, mul_a and mul_b never change in ISSUE or WAIT.
- Width: operands pass through unmodified. Sign extension and high/low selection are done by the multiplier, keyed by mul_sel.

## Timing
- Reset (rst_n=0 at posedge): state IDLE; mul_sel=000; mul_a=mul_b=0; wb_valid=0; wb_rd=0; wb_data=0.
- Reset mid-operation aborts with no wb_valid. mul_sel=000 afterwards lets the multiplier self-reset.
- Nominal latency, with the accept cycle as cycle 0:
  - cycle 0: accept; stall=1.
  - cycle 1: ISSUE, mul_sel valid.
  - cycle 2: WAIT.
  - cycle 3: mul_ready=1; capture; stall=0.
  - cycle 4: wb_valid=1, wb_data valid; DRAIN.
  - cycle 5: DRAIN with mul_ready=0.
  - cycle 6: IDLE.
- Back-to-back: a second multiply arriving in cycle 4 stalls in DRAIN and is accepted in cycle 6. Its mul_sel is driven in cycle 7 or later, so the multiplier has seen mul_sel=000 with ready low for at least one edge.
- wb_valid is high for exactly one cycle per completed, unflushed operation.
- wb_rd and wb_data hold their values until the next capture.

## Configuration
- MUL_ZERO_BYPASS_EN defined:
  - In IDLE, a req_mul with req_rs1==0 or req_rs2==0 skips the multiplier.
  - stall=0; wb_valid=1 next cycle with wb_data=0 and wb_rd=req_rd.
  - State stays IDLE; mul_sel stays 000.
- MUL_ZERO_BYPASS_EN undefined: zero operands take the normal path with the nominal latency.

## Test plan
- mul, rs1=7, rs2=6 -> stall high for cycles 0–2; wb_valid in cycle 4 with wb_data=42 and the request's rd; mul_sel=001 in cycles 1–3 and 000 in cycle 4.
- mulhu, rs1=rs2=0xFFFFFFFF -> wb_data=0xFFFFFFFE. mulh with the same operands -> 0x00000000. mulhsu with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- Two consecutive mul requests -> second accepted only after DRAIN sees mul_ready=0; two wb_valid pulses with correct rd each; no stale result.
- flush in WAIT on the same cycle as mul_ready -> no wb_valid; DRAIN then IDLE; the following mul 3×5 gives 15.
- rst_n low during WAIT -> all outputs 0 next cycle; the next request completes normally. funct3=100 request -> stall=0 and no activity.
- With MUL_ZERO_BYPASS_EN: mul with rs2=0 -> stall=0, wb_valid in cycle 1 with data 0, mul_sel stays 000. Without the macro: wb_valid in cycle 4 with data 0.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Issue/capture controller between the EX-stage operand path and an iterative
// multiplier. It accepts RV32M multiply requests (funct3 000-011) and latches
// their operands. The multiplier select stays stable for the whole operation,
// and the pipeline is stalled until the result is captured. After that the
// select is parked at 000 until the multiplier drops its ready level, so the
// multiplier always self-resets between operations. Each completed, unflushed
// operation produces a one-cycle writeback strobe.
//
// Optional feature: define MUL_ZERO_BYPASS_EN so that a request with a zero
// operand completes in IDLE without using the multiplier.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/funct3/rs1/rs2/rd   request from EX (funct3[2]=1 is ignored)
//   flush                 kills any in-flight operation
//   stall                 combinational hold for IF/ID/EX
//   mul_sel, mul_a, mul_b registered select/operands to the multiplier
//                         (001..100 = mul/mulh/mulhsu/mulhu, 000 = idle)
//   mul_ready, mul_res    multiplier result-valid level and result
//   wb_valid, wb_rd, wb_data   one-cycle writeback strobe, held rd/data
// -----------------------------------------------------------------------------
module mul_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic [2:0]  mul_sel,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic [31:0] mul_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [2:0]  mul_sel_q,  mul_sel_d;
    logic [31:0] mul_a_q,    mul_a_d;
    logic [31:0] mul_b_q,    mul_b_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q,    wb_rd_d;
    logic [31:0] wb_data_q,  wb_data_d;

    logic req_mul;
    logic capture;
    logic bypass;

    always_comb begin
        req_mul = req_valid && !req_funct3[2];
        // A result is taken only in WAIT; flush on the same cycle wins.
        capture = (state_q == WAIT) && mul_ready && !flush;
`ifdef MUL_ZERO_BYPASS_EN
        bypass  = (state_q == IDLE) && req_mul && !flush &&
                  ((req_rs1 == 32'd0) || (req_rs2 == 32'd0));
`else
        bypass  = 1'b0;
`endif
        // Releasing stall on the capture cycle lets EX advance so the
        // writeback lands exactly one cycle later.
        stall   = req_mul && !capture && !bypass;
    end

    always_comb begin
        state_d    = state_q;
        mul_sel_d  = mul_sel_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            IDLE: begin
                mul_sel_d = 3'b000;
                if (bypass) begin
                    // Product of a zero operand is zero; never touch the multiplier.
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_rd;
                    wb_data_d  = 32'd0;
                end else if (req_mul && !flush) begin
                    mul_sel_d = 3'(req_funct3 + 3'd1);
                    mul_a_d   = req_rs1;
                    mul_b_d   = req_rs2;
                    wb_rd_d   = req_rd;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    mul_sel_d = 3'b000;
                    state_d   = DRAIN;
                end else begin
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    mul_sel_d = 3'b000;
                    state_d   = DRAIN;
                end else if (mul_ready) begin
                    mul_sel_d  = 3'b000;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mul_res;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // Hold select at idle until the multiplier has dropped ready.
                mul_sel_d = 3'b000;
                if (!mul_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mul_sel_d = 3'b000;
                state_d   = IDLE;
            end
        endcase
    end

    // wb_rd is loaded at accept time; it only becomes visible meaning-wise
    // with the strobe, but it must not change between captures, so keep a
    // separate pending rd and commit it on capture.
    logic [4:0] pend_rd_q, pend_rd_d;

    always_comb begin
        pend_rd_d = pend_rd_q;
        if (state_q == IDLE && !bypass && req_mul && !flush) begin
            pend_rd_d = req_rd;
        end
    end

    logic [4:0] wb_rd_out_d;

    always_comb begin
        wb_rd_out_d = wb_rd_q;
        if (capture) begin
            wb_rd_out_d = pend_rd_q;
        end else if (bypass) begin
            wb_rd_out_d = req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mul_sel_q  <= 3'b000;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            pend_rd_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            mul_sel_q  <= mul_sel_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_out_d;
            wb_data_q  <= wb_data_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

    // wb_rd_d from the main block is superseded by the pending-rd path.
    logic unused_wb_rd;
    assign unused_wb_rd = ^wb_rd_d;

    assign mul_sel  = mul_sel_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: multiplier stub, cycle-level reference model
// checked on every falling edge, and directed scenarios with literal checks.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic [2:0]  mul_sel;
    logic [31:0] mul_a, mul_b;
    logic        mul_ready;
    logic [31:0] mul_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mul_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
        .stall(stall), .mul_sel(mul_sel), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_res(mul_res), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data)
    );

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // RV32M product by plain 64-bit arithmetic on extended operands.
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Multiplier stub: result ready two edges after it first sees a select,
    // ready drops one edge after the select returns to idle.
    int  stub_cnt   = 0;
    logic stub_ready = 1'b0;
    always @(posedge clk) begin
        if (mul_sel == 3'd0 || mul_sel === 3'bxxx) begin
            stub_cnt   <= 0;
            stub_ready <= 1'b0;
        end else begin
            stub_cnt   <= stub_cnt + 1;
            stub_ready <= (stub_cnt + 1 >= 2);
        end
    end
    assign mul_ready = stub_ready;
    assign mul_res   = (mul_sel == 3'd0) ? 32'hDEADBEEF : golden(3'(mul_sel - 3'd1), mul_a, mul_b);

    // Reference model: an operation is busy from accept until the drain ends.
    bit          busy = 0, drain = 0;
    int          age  = 0;
    logic [2:0]  op_f3;
    logic [4:0]  op_rd;
    logic [31:0] op_a, op_b;
    logic [2:0]  e_sel  = 0;
    logic [31:0] e_a    = 0, e_b = 0, e_data = 0;
    logic        e_wbv  = 0;
    logic [4:0]  e_rd   = 0;
    bit          m_req, m_byp, m_cap, m_stall;

    always @(negedge clk) begin
        m_req   = req_valid && !req_funct3[2];
        m_byp   = BYP && !busy && m_req && !flush && (req_rs1 == 0 || req_rs2 == 0);
        m_cap   = busy && !drain && age >= 2 && (mul_ready === 1'b1) && !flush;
        m_stall = m_req && !m_cap && !m_byp;
        if (started) begin
            chk("mdl_stall", 32'(stall), 32'(m_stall));
            chk("mdl_sel", 32'(mul_sel), 32'(e_sel));
            chk("mdl_a", mul_a, e_a);
            chk("mdl_b", mul_b, e_b);
            chk("mdl_wbv", 32'(wb_valid), 32'(e_wbv));
            chk("mdl_rd", 32'(wb_rd), 32'(e_rd));
            chk("mdl_data", wb_data, e_data);
        end
        if (!rst_n) begin
            busy = 0; drain = 0; age = 0;
            e_sel = 0; e_a = 0; e_b = 0; e_wbv = 0; e_rd = 0; e_data = 0;
        end else begin
            e_wbv = m_cap || m_byp;
            if (m_cap) begin e_data = golden(op_f3, op_a, op_b); e_rd = op_rd; end
            if (m_byp) begin e_data = 0; e_rd = req_rd; end
            if (!busy) begin
                if (m_req && !flush && !m_byp) begin
                    busy = 1; drain = 0; age = 1;
                    op_f3 = req_funct3; op_rd = req_rd; op_a = req_rs1; op_b = req_rs2;
                    e_sel = 3'(req_funct3 + 3'd1); e_a = req_rs1; e_b = req_rs2;
                end
            end else if (drain) begin
                if (!mul_ready) busy = 0;
            end else if (flush || m_cap) begin
                drain = 1; e_sel = 0;
            end else begin
                age++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        req_valid = 1'b1; req_funct3 = f; req_rs1 = a; req_rs2 = b; req_rd = rd;
    endtask

    // Present a request (held while stalled) and wait for its writeback.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] data,
                          output logic [4:0] wrd, output int lat);
        bit s;
        set_req(f, a, b, rd);
        lat = -1; data = 0; wrd = 0;
        for (int c = 0; c < 30; c++) begin
            smp();
            if (wb_valid && lat < 0) begin lat = c; data = wb_data; wrd = wb_rd; end
            s = stall;
            step();
            if (!s) req_valid = 1'b0;
            if (lat >= 0) break;
        end
        req_valid = 1'b0;
        repeat (2) step();
    endtask

    logic [31:0] d;
    logic [4:0]  r;
    int          lat, gap, wbcnt;
    bit          s;

    initial begin
        rst_n = 1'b0; req_valid = 0; req_funct3 = 0; req_rs1 = 0; req_rs2 = 0;
        req_rd = 0; flush = 0;
        step(); started = 1'b1;
        step();
        smp();
        chk("rst_sel", 32'(mul_sel), 0);
        chk("rst_a", mul_a, 0);
        chk("rst_b", mul_b, 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_rd", 32'(wb_rd), 0);
        chk("rst_data", wb_data, 0);
        step(); rst_n = 1'b1;
        step();

        // mul 7*6 with cycle-exact checks
        set_req(3'd0, 32'd7, 32'd6, 5'd5);
        smp(); chk("t1_c0_stall", 32'(stall), 1); chk("t1_c0_sel", 32'(mul_sel), 0);
        step(); smp(); chk("t1_c1_stall", 32'(stall), 1); chk("t1_c1_sel", 32'(mul_sel), 1);
        step(); smp(); chk("t1_c2_stall", 32'(stall), 1); chk("t1_c2_sel", 32'(mul_sel), 1);
        step(); smp(); chk("t1_c3_stall", 32'(stall), 0); chk("t1_c3_sel", 32'(mul_sel), 1);
        chk("t1_c3_wbv", 32'(wb_valid), 0);
        step(); req_valid = 1'b0;
        smp(); chk("t1_c4_wbv", 32'(wb_valid), 1); chk("t1_c4_data", wb_data, 32'd42);
        chk("t1_c4_rd", 32'(wb_rd), 5); chk("t1_c4_sel", 32'(mul_sel), 0);
        step(); smp(); chk("t1_c5_wbv", 32'(wb_valid), 0);
        step(); step();

        // high-half variants
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, d, r, lat);
        chk("mulhu_data", d, 32'hFFFFFFFE); chk("mulhu_rd", 32'(r), 7); chk("mulhu_lat", 32'(lat), 4);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, d, r, lat);
        chk("mulh_data", d, 32'h0); chk("mulh_rd", 32'(r), 8);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd9, d, r, lat);
        chk("mulhsu_data", d, 32'hFFFFFFFF); chk("mulhsu_rd", 32'(r), 9);

        // back-to-back: second request arrives in cycle 4, accepted in cycle 6
        set_req(3'd0, 32'd3, 32'd4, 5'd1);
        for (int c = 0; c < 10; c++) begin
            smp();
            if (!stall) break;
            step();
        end
        step(); set_req(3'd0, 32'd9, 32'd9, 5'd2);
        smp(); chk("b2b_wb1", 32'(wb_valid), 1); chk("b2b_d1", wb_data, 32'd12);
        chk("b2b_rd1", 32'(wb_rd), 1);
        s = stall; gap = -1;
        for (int c = 1; c < 20; c++) begin
            step(); if (!s) req_valid = 1'b0;
            smp(); s = stall;
            if (wb_valid) begin
                gap = c; chk("b2b_d2", wb_data, 32'd81); chk("b2b_rd2", 32'(wb_rd), 2);
                break;
            end
        end
        chk("b2b_gap", 32'(gap), 6);
        req_valid = 1'b0;
        repeat (2) step();

        // flush in WAIT on the same cycle as mul_ready
        set_req(3'd0, 32'd100, 32'd100, 5'd3);
        smp(); step(); smp(); step(); smp(); step();
        flush = 1'b1;
        smp(); chk("fl_ready", 32'(mul_ready), 1); chk("fl_stall", 32'(stall), 1);
        step(); flush = 1'b0; req_valid = 1'b0;
        wbcnt = 0;
        for (int c = 0; c < 4; c++) begin
            smp(); if (wb_valid) wbcnt++;
            step();
        end
        chk("fl_nowb", 32'(wbcnt), 0);
        chk("fl_hold", wb_data, 32'd81);
        run_op(3'd0, 32'd3, 32'd5, 5'd11, d, r, lat);
        chk("fl_next_data", d, 32'd15); chk("fl_next_rd", 32'(r), 11);

        // reset during WAIT
        set_req(3'd0, 32'd5, 32'd5, 5'd4);
        step(); step(); smp();
        step(); rst_n = 1'b0; req_valid = 1'b0;
        step(); rst_n = 1'b1;
        smp();
        chk("rw_sel", 32'(mul_sel), 0); chk("rw_a", mul_a, 0); chk("rw_b", mul_b, 0);
        chk("rw_wbv", 32'(wb_valid), 0); chk("rw_rd", 32'(wb_rd), 0); chk("rw_data", wb_data, 0);
        step();
        run_op(3'd3, 32'h00010000, 32'h00010000, 5'd12, d, r, lat);
        chk("rw_next_data", d, 32'd1); chk("rw_next_lat", 32'(lat), 4);

        // funct3=100 is not a multiply
        set_req(3'd4, 32'd3, 32'd3, 5'd6);
        for (int c = 0; c < 3; c++) begin
            smp(); chk("f4_stall", 32'(stall), 0); chk("f4_sel", 32'(mul_sel), 0);
            chk("f4_wbv", 32'(wb_valid), 0);
            step();
        end
        req_valid = 1'b0;
        step();

        // zero operand
        run_op(3'd0, 32'd1234, 32'd0, 5'd13, d, r, lat);
        chk("zero_data", d, 32'd0); chk("zero_rd", 32'(r), 13);
        chk("zero_lat", 32'(lat), BYP ? 32'd1 : 32'd4);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
